hub75_column_driver: RTL and testbench

Sequential HUB75 output stage of the spinning display, directly downstream of `boids_frame`. Once per frame it latches the current discretized angle and walks all `SCAN_RATE` scan lines. For each line it fetches the two `NUM_ROWS`-pixel columns from the frame generator and drives them into the LED panel. It uses binary-coded modulation (BCM) with `RGB_RES/3` bit planes per colour.

---
 rtl/hub75_column_driver.sv | 160 ++++++++++++++++
 tb/tb_hub75_column_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_column_driver.sv
// HUB75 column driver: per frame, latches the rotor angle and walks every scan line,
// shifting both lanes out once per BCM bit plane before latching and lighting them.
module hub75_column_driver #(
    parameter int SCAN_RATE      = 32,
    parameter int NUM_ROWS       = 64,
    parameter int RGB_RES        = 9,
    parameter int ROTATIONAL_RES = 256,
    parameter int BASE_HOLD      = 16
) (
    input  logic                                         clk_in,
    input  logic                                         rst_n_in,
    input  logic                                         en_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]            dtheta_in,
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]        columns_in,
    output logic [$clog2(ROTATIONAL_RES)-1:0]            dtheta_out,
    output logic [$clog2(SCAN_RATE)-1:0]                 column_index1_out,
    output logic [$clog2(SCAN_RATE)-1:0]                 column_index2_out,
    output logic [1:0]                                   hub_r_out,
    output logic [1:0]                                   hub_g_out,
    output logic [1:0]                                   hub_b_out,
    output logic [$clog2(SCAN_RATE)-1:0]                 hub_addr_out,
    output logic                                         hub_clk_out,
    output logic                                         hub_latch_out,
    output logic                                         hub_oe_n_out,
    output logic                                         frame_done_out
);
    localparam int PB       = RGB_RES / 3;
    localparam int AW       = $clog2(SCAN_RATE);
    localparam int TW       = $clog2(ROTATIONAL_RES);
    localparam int BW       = (PB > 1) ? $clog2(PB) : 1;
    localparam int CW       = $clog2(2 * NUM_ROWS);
    localparam int HOLD_MAX = BASE_HOLD << (PB - 1);
    localparam int HW       = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {S_SYNC, S_FETCH, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

    state_t                                  state_q, state_d;
    logic [AW-1:0]                           s_q, s_d;
    logic [BW-1:0]                           b_q, b_d;
    logic [CW-1:0]                           cnt_q, cnt_d;
    logic [HW-1:0]                           hold_q, hold_d;
    logic [HW-1:0]                           hold_last;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   buf_q, buf_d;
    logic [TW-1:0]                           theta_q, theta_d;
    logic [AW-1:0]                           addr_q, addr_d;

    logic [RGB_RES-1:0] pix_lane [2];
    logic [PB-1:0]      r_fld    [2];
    logic [PB-1:0]      g_fld    [2];
    logic [PB-1:0]      b_fld    [2];

    // cnt_q walks two cycles per pixel: its upper bits pick the pixel, bit 0 is the shift clock
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign pix_lane[gi] = buf_q[gi][cnt_q[CW-1:1]];
            assign r_fld[gi]    = pix_lane[gi][3*PB-1:2*PB];
            assign g_fld[gi]    = pix_lane[gi][2*PB-1:PB];
            assign b_fld[gi]    = pix_lane[gi][PB-1:0];
        end
    endgenerate

    assign hold_last         = (HW'(BASE_HOLD) << b_q) - HW'(1);
    assign dtheta_out        = theta_q;
    assign column_index1_out = s_q;
    assign column_index2_out = s_q;
    assign hub_addr_out      = addr_q;

    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        b_d            = b_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        buf_d          = buf_q;
        theta_d        = theta_q;
        addr_d         = addr_q;
        hub_r_out      = 2'b00;
        hub_g_out      = 2'b00;
        hub_b_out      = 2'b00;
        hub_clk_out    = 1'b0;
        hub_latch_out  = 1'b0;
        hub_oe_n_out   = 1'b1;
        frame_done_out = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (en_in) begin
                    theta_d = dtheta_in;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                buf_d   = columns_in;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                hub_clk_out = cnt_q[0];
                hub_r_out   = {r_fld[1][b_q], r_fld[0][b_q]};
                hub_g_out   = {g_fld[1][b_q], g_fld[0][b_q]};
                hub_b_out   = {b_fld[1][b_q], b_fld[0][b_q]};
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(2 * NUM_ROWS - 1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                hub_latch_out = 1'b1;
                addr_d        = s_q;
                hold_d        = '0;
                state_d       = S_DISPLAY;
            end
            S_DISPLAY: begin
                hub_oe_n_out = 1'b0;
                hold_d       = hold_q + HW'(1);
                if (hold_q == hold_last) begin
                    hold_d = '0;
                    if (b_q != BW'(PB - 1)) begin
                        // next plane reuses the buffered columns
                        b_d     = b_q + BW'(1);
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else if (s_q != AW'(SCAN_RATE - 1)) begin
                        b_d     = '0;
                        s_d     = s_q + AW'(1);
                        state_d = S_FETCH;
                    end else begin
                        b_d            = '0;
                        s_d            = '0;
                        frame_done_out = 1'b1;
                        state_d        = S_SYNC;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_SYNC;
            s_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            buf_q   <= '0;
            theta_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            buf_q   <= buf_d;
            theta_q <= theta_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_hub75_column_driver.sv
// Bench for hub75_column_driver: cycle-by-cycle timeline model of a frame, a plane table
// for a fixed pixel pattern, enable gating and an asynchronous reset during line 17.
module tb_hub75_column_driver;
    logic                     clk_in = 1'b0;
    logic                     rst_n_in = 1'b0;
    logic                     en_in = 1'b1;
    logic [7:0]               dtheta_in = 8'h5A;
    logic [1:0][63:0][8:0]    columns_in;
    logic [7:0]               dtheta_out;
    logic [4:0]               idx1, idx2, hub_addr;
    logic [1:0]               hub_r, hub_g, hub_b;
    logic                     hub_clk, hub_latch, hub_oe_n, frame_done;

    logic [8:0] pix_mem [0:1][0:31][0:63];
    logic       pattern_mode = 1'b0;
    int         errors = 0;
    int         checks = 0;

    hub75_column_driver dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .dtheta_in(dtheta_in),
        .columns_in(columns_in), .dtheta_out(dtheta_out),
        .column_index1_out(idx1), .column_index2_out(idx2),
        .hub_r_out(hub_r), .hub_g_out(hub_g), .hub_b_out(hub_b), .hub_addr_out(hub_addr),
        .hub_clk_out(hub_clk), .hub_latch_out(hub_latch), .hub_oe_n_out(hub_oe_n),
        .frame_done_out(frame_done)
    );

    always #5 clk_in = ~clk_in;

    // frame generator stand-in: combinational lookup by the requested column index
    always_comb begin
        columns_in = '0;
        for (int k = 0; k < 64; k++) begin
            if (pattern_mode) begin
                columns_in[0][k] = 9'b111_000_101;
                columns_in[1][k] = 9'b000_111_010;
            end else begin
                columns_in[0][k] = pix_mem[0][idx1][k];
                columns_in[1][k] = pix_mem[1][idx2][k];
            end
        end
    end

    typedef struct packed {
        logic       oe_n, clk, latch, fd;
        logic [1:0] r, g, b;
        logic [4:0] idx1, idx2, addr;
    } obs_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs t cycles after reset release (t=0 is the first SYNC cycle),
    // derived from the line/plane cycle budget: 1 fetch + per plane 128 shift, 1 latch, 16<<b lit.
    function automatic obs_t model(input int t);
        obs_t e;
        int u, line, r, q, len, p;
        e = '0;
        e.oe_n = 1'b1;
        if (t == 0) return e;
        u = t - 1;
        line = u / 500;
        r = u % 500;
        e.idx1 = 5'(line);
        e.idx2 = 5'(line);
        e.addr = (r > 129) ? 5'(line) : ((line == 0) ? 5'd0 : 5'(line - 1));
        if (r == 0) return e;
        q = r - 1;
        for (int pb = 0; pb < 3; pb++) begin
            len = 129 + (16 << pb);
            if (q < len) begin
                if (q < 128) begin
                    p = q / 2;
                    e.clk = q[0];
                    for (int l = 0; l < 2; l++) begin
                        e.r[l] = pix_mem[l][line][p][6 + pb];
                        e.g[l] = pix_mem[l][line][p][3 + pb];
                        e.b[l] = pix_mem[l][line][p][pb];
                    end
                end else if (q == 128) begin
                    e.latch = 1'b1;
                end else begin
                    e.oe_n = 1'b0;
                    e.fd = (line == 31) && (pb == 2) && (q == len - 1);
                end
                return e;
            end
            q -= len;
        end
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t a;
        a.oe_n = hub_oe_n; a.clk = hub_clk; a.latch = hub_latch; a.fd = frame_done;
        a.r = hub_r; a.g = hub_g; a.b = hub_b;
        a.idx1 = idx1; a.idx2 = idx2; a.addr = hub_addr;
        return a;
    endfunction

    task automatic chk_trace(input int t);
        chk($sformatf("trace@%0d", t), 64'(observe()), 64'(model(t)));
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
    endtask

    typedef struct {
        int         plane;
        logic [1:0] r, g, b;
        int         hold;
        int         edges;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[3];
        logic [7:0] new_theta;
        int         runs[3], edges[3], bad[3], seen[3];
        logic [1:0] rs[3], gs[3], bs[3];
        int         plane, run;
        logic       prev_clk;
        int         oe_low, clk_hi;
        logic       found;

        vecs[0] = '{0, 2'b01, 2'b10, 2'b01, 16, 64};
        vecs[1] = '{1, 2'b01, 2'b10, 2'b10, 32, 64};
        vecs[2] = '{2, 2'b01, 2'b10, 2'b01, 64, 64};

        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 32; s++)
                for (int k = 0; k < 64; k++)
                    pix_mem[l][s][k] = 9'($urandom);

        // reset state
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_oe_n", hub_oe_n, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_dtheta", dtheta_out, 0);
        chk("rst_addr_idx", {hub_addr, idx1, idx2}, 0);
        chk("rst_clk_latch_rgb", {hub_clk, hub_latch, hub_r, hub_g, hub_b}, 0);

        // full frame with random pixels, angle change and enable drop mid-frame
        new_theta = 8'($urandom);
        if (new_theta == 8'h5A) new_theta = 8'hA5;
        release_reset();
        for (int t = 0; t <= 16010; t++) begin
            if (t <= 16000) chk_trace(t);
            else chk("sync_idle", {hub_oe_n, hub_clk, frame_done}, 3'b100);
            if (t >= 1) chk("dtheta_hold", dtheta_out, 8'h5A);
            if (t == 5000) dtheta_in = new_theta;
            if (t == 8000) en_in = 1'b0;
            if (t == 16010) en_in = 1'b1;
            @(negedge clk_in);
            #1;
        end
        chk("resume_fetch", {dtheta_out, idx1, hub_oe_n, hub_clk}, {new_theta, 5'd0, 1'b1, 1'b0});
        @(negedge clk_in); #1;
        chk("resume_shift_lo", hub_clk, 0);
        @(negedge clk_in); #1;
        chk("resume_shift_hi", hub_clk, 1);

        // enable held low: parked in SYNC, then FETCH one cycle after raising it
        rst_n_in = 1'b0;
        en_in = 1'b0;
        #1;
        chk("async_rst_oe", hub_oe_n, 1);
        release_reset();
        oe_low = 0;
        clk_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!hub_oe_n) oe_low++;
            if (hub_clk) clk_hi++;
            @(negedge clk_in); #1;
        end
        chk("idle_oe_low_cycles", oe_low, 0);
        chk("idle_clk_high_cycles", clk_hi, 0);
        en_in = 1'b1;
        @(negedge clk_in); #1;
        chk("en_fetch", {hub_oe_n, hub_clk, idx1}, {1'b1, 1'b0, 5'd0});
        @(negedge clk_in); #1;
        chk("en_shift0_lo", hub_clk, 0);
        @(negedge clk_in); #1;
        chk("en_shift0_hi", hub_clk, 1);

        // fixed pattern: per-plane bits, shift clock edges and lit durations of line 0
        rst_n_in = 1'b0;
        pattern_mode = 1'b1;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            runs[i] = 0; edges[i] = 0; bad[i] = 0; seen[i] = 0;
            rs[i] = '0; gs[i] = '0; bs[i] = '0;
        end
        plane = 0;
        run = 0;
        prev_clk = 1'b0;
        for (int t = 0; t <= 501; t++) begin
            if (plane < 3) begin
                if (hub_clk && !prev_clk) edges[plane]++;
                if (hub_clk) begin
                    if (seen[plane] == 0) begin
                        rs[plane] = hub_r; gs[plane] = hub_g; bs[plane] = hub_b;
                        seen[plane] = 1;
                    end else if ({hub_r, hub_g, hub_b} != {rs[plane], gs[plane], bs[plane]}) begin
                        bad[plane]++;
                    end
                end
                if (!hub_oe_n) run++;
                else if (run > 0) begin
                    runs[plane] = run;
                    plane++;
                    run = 0;
                end
            end
            prev_clk = hub_clk;
            @(negedge clk_in); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("plane%0d_r", vecs[i].plane), rs[i], vecs[i].r);
            chk($sformatf("plane%0d_g", vecs[i].plane), gs[i], vecs[i].g);
            chk($sformatf("plane%0d_b", vecs[i].plane), bs[i], vecs[i].b);
            chk($sformatf("plane%0d_hold", vecs[i].plane), runs[i], vecs[i].hold);
            chk($sformatf("plane%0d_edges", vecs[i].plane), edges[i], vecs[i].edges);
            chk($sformatf("plane%0d_unstable", vecs[i].plane), bad[i], 0);
        end
        pattern_mode = 1'b0;

        // asynchronous reset while line 17 is lit, then restart from line 0 plane 0
        rst_n_in = 1'b0;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk_in); #1;
            if (idx1 == 5'd17 && !hub_oe_n) found = 1'b1;
        end
        chk("reach_line17_display", found, 1);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_oe_n", hub_oe_n, 1);
        chk("midrst_state", {idx1, hub_addr, hub_clk, frame_done}, 0);
        release_reset();
        for (int t = 0; t <= 1100; t++) begin
            chk_trace(t);
            @(negedge clk_in); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
